// File: rtl/lab7_pkg.sv
// Shared definitions for the lab7 RISC machine: fetch state encoding,
// the halt opcode and the default address/data widths used by the RAM,
// the fetch sequencer and the datapath.
package lab7_pkg;

  localparam int LAB7_ADDR_W  = 9;
  localparam int LAB7_INSTR_W = 16;

  // Top three instruction bits equal to this value stop the fetch loop.
  localparam logic [2:0] LAB7_HALT_OP = 3'b111;

  // Legacy-compatible state codes; the enum below reuses them so that
  // waveforms and older tools see the same numeric encoding.
  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_IF1  = 3'd1;
  localparam logic [2:0] S_IF2  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  typedef enum logic [2:0] {
    ST_RST  = S_RST,
    ST_IF1  = S_IF1,
    ST_IF2  = S_IF2,
    ST_EXEC = S_EXEC,
    ST_HALT = S_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Program counter: synchronous clear, hold, increment (modulo 2^ADDR_W)
// or load of a branch target. A load takes priority over an increment.
module pc_reg #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  // PC update; the natural adder overflow gives the wrap from max to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_ONE;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Steps RST -> IF1 -> IF2 -> EXEC (or HALT),
// owns the instruction register and muxes the RAM read address between
// the PC and datapath data reads while an instruction executes.
module fetch_ctrl
  import lab7_pkg::*;
#(
  parameter int         ADDR_W  = LAB7_ADDR_W,
  parameter int         INSTR_W = LAB7_INSTR_W,
  parameter logic [2:0] HALT_OP = LAB7_HALT_OP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] mem_dout,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_read,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               br_en,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               dp_mem_req,
  input  logic [ADDR_W-1:0]  dp_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         pc_inc;
  logic         pc_load;

  // The PC advances as the instruction is captured, so EXEC already sees
  // the fall-through address; a taken branch simply overwrites it.
  assign pc_inc  = (state == ST_IF2);
  assign pc_load = (state == ST_EXEC) && exec_done && br_en;

  pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (br_target),
    .pc     (pc)
  );

  // State register; reset forces RST regardless of other inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register loads the RAM word during IF2 only.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= '0;
    end else if (state == ST_IF2) begin
      instr <= mem_dout;
    end else begin
      instr <= instr;
    end
  end

  // Next-state logic; exec_done is only looked at while executing.
  always_comb begin
    state_next = ST_RST;
    case (state)
      ST_RST:  state_next = ST_IF1;
      ST_IF1:  state_next = ST_IF2;
      ST_IF2: begin
        if (mem_dout[INSTR_W-1 -: 3] == HALT_OP) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          state_next = ST_IF1;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase
  end

  // Output decode from state, PC and the EXEC-only datapath request;
  // nothing here depends on mem_dout.
  always_comb begin
    mem_addr    = pc;
    mem_read    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      ST_RST: begin
        mem_addr = pc;
      end
      ST_IF1: begin
        mem_read = 1'b1;
      end
      ST_IF2: begin
        mem_read = 1'b0;
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        mem_read    = dp_mem_req;
        if (dp_mem_req) begin
          mem_addr = dp_addr;
        end else begin
          mem_addr = pc;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        mem_addr = pc;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural RAM with 1-cycle registered
// read, fixed stimulus sequence and hand-computed expected values.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] mem_dout;
  logic [8:0]  mem_addr;
  logic        mem_read;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        br_en;
  logic [8:0]  br_target;
  logic        dp_mem_req;
  logic [8:0]  dp_addr;
  logic [8:0]  pc;
  logic        halted;

  logic [15:0] mem [0:511];

  int vectors;
  int miscompares;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .mem_dout    (mem_dout),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .br_en       (br_en),
    .br_target   (br_target),
    .dp_mem_req  (dp_mem_req),
    .dp_addr     (dp_addr),
    .pc          (pc),
    .halted      (halted)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: registered read of whatever address is presented.
  always @(posedge clk) begin
    mem_dout <= mem[mem_addr];
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land on the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h1234;
    mem[1]   = 16'h5678;
    mem[2]   = 16'hE000;
    mem[64]  = 16'h2222;
    mem[160] = 16'hBEEF;
    mem[511] = 16'h4321;

    reset      = 1'b1;
    exec_done  = 1'b0;
    br_en      = 1'b0;
    br_target  = 9'h000;
    dp_mem_req = 1'b0;
    dp_addr    = 9'h000;

    // Reset held for three edges.
    tick();
    tick();
    check_vec("rst_pc_mid", 32'(pc), 32'h0);
    tick();
    check_vec("rst_pc", 32'(pc), 32'h0);
    check_vec("rst_instr", 32'(instr), 32'h0);
    check_vec("rst_addr", 32'(mem_addr), 32'h0);
    check_vec("rst_valid", 32'(instr_valid), 32'h0);
    check_vec("rst_read", 32'(mem_read), 32'h0);
    check_vec("rst_halted", 32'(halted), 32'h0);

    // Release; IF1 one cycle later.
    reset = 1'b0;
    tick();
    check_vec("if1_read", 32'(mem_read), 32'h1);
    check_vec("if1_addr", 32'(mem_addr), 32'h0);
    check_vec("if1_valid", 32'(instr_valid), 32'h0);

    // Straight-line fetch with exec_done high.
    exec_done = 1'b1;
    tick();
    check_vec("if2_read", 32'(mem_read), 32'h0);
    check_vec("if2_valid", 32'(instr_valid), 32'h0);
    tick();
    check_vec("e3_instr", 32'(instr), 32'h1234);
    check_vec("e3_valid", 32'(instr_valid), 32'h1);
    check_vec("e3_pc", 32'(pc), 32'h1);
    tick();
    check_vec("e4_addr", 32'(mem_addr), 32'h1);
    tick();
    tick();
    check_vec("e6_instr", 32'(instr), 32'h5678);
    check_vec("e6_pc", 32'(pc), 32'h2);

    // br_en without exec_done is ignored.
    exec_done = 1'b0;
    br_en     = 1'b1;
    br_target = 9'h040;
    tick();
    check_vec("br_noexec_pc", 32'(pc), 32'h2);
    check_vec("br_noexec_valid", 32'(instr_valid), 32'h1);

    // Taken branch.
    exec_done = 1'b1;
    tick();
    check_vec("br_if1_addr", 32'(mem_addr), 32'h040);
    check_vec("br_if1_read", 32'(mem_read), 32'h1);
    exec_done = 1'b0;
    br_en     = 1'b0;
    tick();
    tick();
    check_vec("br_instr", 32'(instr), 32'h2222);
    check_vec("br_pc", 32'(pc), 32'h041);

    // Branch to the last address and wrap.
    exec_done = 1'b1;
    br_en     = 1'b1;
    br_target = 9'h1FF;
    tick();
    check_vec("wrap_if1_addr", 32'(mem_addr), 32'h1FF);
    exec_done = 1'b0;
    br_en     = 1'b0;
    tick();
    tick();
    check_vec("wrap_instr", 32'(instr), 32'h4321);
    check_vec("wrap_pc", 32'(pc), 32'h0);
    exec_done = 1'b1;
    tick();
    check_vec("wrap_fetch_addr", 32'(mem_addr), 32'h0);
    exec_done = 1'b0;
    tick();
    tick();
    check_vec("wrap_fetch_instr", 32'(instr), 32'h1234);
    check_vec("wrap_fetch_pc", 32'(pc), 32'h1);

    // Datapath read in EXEC.
    dp_mem_req = 1'b1;
    dp_addr    = 9'h0A0;
    #1;
    check_vec("dp_addr", 32'(mem_addr), 32'h0A0);
    check_vec("dp_read", 32'(mem_read), 32'h1);
    tick();
    check_vec("dp_data", 32'(mem_dout), 32'hBEEF);
    check_vec("dp_hold_valid", 32'(instr_valid), 32'h1);

    // dp_mem_req outside EXEC is ignored.
    exec_done = 1'b1;
    tick();
    check_vec("dp_if1_addr", 32'(mem_addr), 32'h1);
    check_vec("dp_if1_read", 32'(mem_read), 32'h1);
    tick();
    check_vec("dp_if2_read", 32'(mem_read), 32'h0);
    check_vec("dp_if2_addr", 32'(mem_addr), 32'h1);
    dp_mem_req = 1'b0;
    tick();
    check_vec("pre_halt_instr", 32'(instr), 32'h5678);
    check_vec("pre_halt_pc", 32'(pc), 32'h2);

    // Fetch of the halt word at mem[2].
    tick();
    tick();
    dp_mem_req = 1'b1;
    tick();
    check_vec("halt_flag", 32'(halted), 32'h1);
    check_vec("halt_instr", 32'(instr), 32'hE000);
    check_vec("halt_pc", 32'(pc), 32'h3);
    check_vec("halt_read", 32'(mem_read), 32'h0);
    check_vec("halt_valid", 32'(instr_valid), 32'h0);
    check_vec("halt_addr", 32'(mem_addr), 32'h3);
    tick();
    check_vec("halt_stay", 32'(halted), 32'h1);
    check_vec("halt_stay_read", 32'(mem_read), 32'h0);
    dp_mem_req = 1'b0;

    // Leave HALT through reset, then reset mid-EXEC with a branch pending.
    reset     = 1'b1;
    exec_done = 1'b0;
    tick();
    check_vec("halt_rst_flag", 32'(halted), 32'h0);
    reset = 1'b0;
    tick();
    tick();
    tick();
    check_vec("re_instr", 32'(instr), 32'h1234);
    check_vec("re_pc", 32'(pc), 32'h1);
    reset     = 1'b1;
    exec_done = 1'b1;
    br_en     = 1'b1;
    br_target = 9'h040;
    tick();
    check_vec("midrst_pc", 32'(pc), 32'h0);
    check_vec("midrst_instr", 32'(instr), 32'h0);
    check_vec("midrst_valid", 32'(instr_valid), 32'h0);
    check_vec("midrst_read", 32'(mem_read), 32'h0);
    reset     = 1'b0;
    exec_done = 1'b0;
    br_en     = 1'b0;
    tick();
    check_vec("midrst_if1_addr", 32'(mem_addr), 32'h0);
    check_vec("midrst_if1_read", 32'(mem_read), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the lab7 RISC machine. It owns the program counter and instruction register and drives the read address of the instruction/data RAM, which has a 1-cycle registered read. It steps a fetch state machine, then presents the instruction to the datapath controller with a valid/done handshake. During execute it arbitrates the RAM address between the PC and datapath data accesses.

## Interface
Parameters:
- `ADDR_W`, 9: PC / memory address width.
- `INSTR_W`, 16: instruction width, equal to the RAM data width.
- `HALT_OP`, 3'b111: opcode in `instr[INSTR_W-1 -: 3]` that halts fetch.

Ports:
- `clk`  in  1: single clock, all state on posedge.
- `reset`  in  1: synchronous, active-high, overrides every other input.
- `mem_dout`  in  INSTR_W: RAM read data, valid the cycle after an address is presented.
- `mem_addr`  out  ADDR_W: RAM read address.
- `mem_read`  out  1: high when `mem_addr` is a fetch or data read.
- `instr`  out  INSTR_W: instruction register contents.
- `instr_valid`  out  1: high while in EXEC.
- `exec_done`  in  1: datapath has finished the current instruction; sampled only in EXEC.
- `br_en`  in  1: with `exec_done`, load `br_target` into the PC.
- `br_target`  in  ADDR_W: branch destination.
- `dp_mem_req`  in  1: datapath data read request; honoured only in EXEC.
- `dp_addr`  in  ADDR_W: datapath data address.
- `pc`  out  ADDR_W: current PC, for debug LEDs and link operations.
- `halted`  out  1: high in HALT.

## Operation
States: RST, IF1, IF2, EXEC, HALT.

- **RST**
  - `pc`=0, `instr`=0, all strobes low.
  - Always goes to IF1 on the next cycle.
- **IF1**
  - `mem_addr`=`pc`, `mem_read`=1.
  - Goes to IF2.
- **IF2**
  - `mem_dout` now holds mem[`pc`].
  - At the posedge: `instr`<=`mem_dout`, `pc`<=`pc`+1.
  - Next state is HALT if `mem_dout[INSTR_W-1 -: 3]`==HALT_OP, else EXEC.
  - `mem_addr`=`pc`, `mem_read`=0.
- **EXEC**
  - `instr_valid`=1.
  - `mem_addr`=`dp_mem_req` ? `dp_addr` : `pc`; `mem_read`=`dp_mem_req`.
  - On `exec_done`=1: go to IF1, and `pc`<=`br_target` if `br_en`, otherwise `pc` is unchanged (already incremented).
  - Stays in EXEC while `exec_done`=0, with no time-out.
- **HALT**
  - `halted`=1, `instr` holds the HALT word, `pc` = halt address + 1.
  - All strobes low, `mem_addr`=`pc`.
  - Left only by `reset`.

Arithmetic and boundary rules:
- PC increment is modulo 2^ADDR_W: 511 + 1 = 0, no flag.
- `br_en` without `exec_done` is ignored.
- `exec_done` and `br_en` together: the branch wins over the already-applied increment.
- `dp_mem_req` outside EXEC is ignored; `mem_addr` follows the state rule.
- `reset` in any state, including mid-EXEC with `exec_done` asserted: next state is RST, `pc`=0, `instr`=0, with no PC or IR update from that cycle.
- `exec_done` is level-sampled. The datapath must drop it before the next EXEC; the IF1 and IF2 cycles give it 2 cycles to do so.

## Timing
- Reset values: `pc`=0, `instr`=0, `instr_valid`=0, `mem_read`=0, `halted`=0, `mem_addr`=0.
- First fetch: `reset` deasserted at edge E0 puts the block in RST. IF1 follows at E1, IF2 at E2, and at E3 `instr`=mem[0] with `instr_valid`=1.
- Minimum instruction period is 3 cycles (IF1, IF2, EXEC with `exec_done` in its first cycle).
- Data read in EXEC: `dp_addr` presented in cycle N gives `mem_dout` in cycle N+1. The datapath must hold EXEC (no `exec_done`) until it captures the data.
- All outputs are combinational from state, `pc` and the EXEC-only inputs. There are no paths from `mem_dout` to outputs.

## Structure
- Shared package `lab7_pkg`:
  - state encoding enum `fetch_state_t` (RST, IF1, IF2, EXEC, HALT);
  - the `HALT_OP` constant;
  - the `ADDR_W` and `INSTR_W` defaults, shared with RAM and the datapath.
- One sub-module, `pc_reg`: ADDR_W register with synchronous reset to 0 and select among hold / +1 / `br_target`.
- The FSM, IR and address mux stay in `fetch_ctrl`.

## Test plan
- Reset: hold `reset` 3 cycles, then release.
  - During and after reset: `pc`=0, `instr`=0, `mem_addr`=0, `instr_valid`=0.
  - IF1 is entered exactly 1 cycle after release.
- Straight-line fetch: mem[0]=16'h1234, mem[1]=16'h5678, `exec_done` tied high.
  - `instr`=16'h1234 at E3, 16'h5678 at E6.
  - `pc` reads 1 then 2.
- Branch: at mem[1], assert `exec_done`+`br_en` with `br_target`=9'h040.
  - The next IF1 drives `mem_addr`=9'h040.
  - Assert `br_en` without `exec_done` and check the PC is unchanged.
- Wrap: branch to 9'h1FF, where mem[511] is a non-halt word.
  - After IF2, `pc`=0; the following fetch reads mem[0].
- Data access and halt:
  - In EXEC, `dp_mem_req`=1 with `dp_addr`=9'h0A0 gives `mem_addr`=9'h0A0 and `mem_read`=1, and `mem_dout` returns mem[160] the next cycle.
  - Fetching 16'hE000 asserts `halted` and stops all `mem_read`.
- Reset mid-EXEC: assert `reset` together with `exec_done`+`br_en`.
  - Next cycle the block is in RST with `pc`=0 and `instr`=0; no branch is taken.
